// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch lookup and execute resolve signals between the core and the predictor.
// Fetch:   F_PC -> Pred_Taken, Pred_Target
// Execute: Ex_Valid, Cur_PC, Imm, AluResult, Branch/Jal/Jalr/Halt, Ex_PredTaken, Ex_PredTarget
//          -> Mispredict, RedirectPC, PcSel, Link
// Perf:    BrCount, MissCount
interface branch_predict_unit_if #(
    parameter int PC_W = 9
);
    logic [PC_W-1:0] F_PC;
    logic            Pred_Taken;
    logic [PC_W-1:0] Pred_Target;
    logic            Ex_Valid;
    logic [PC_W-1:0] Cur_PC;
    logic [31:0]     Imm;
    logic [31:0]     AluResult;
    logic            Branch;
    logic            Jal;
    logic            Jalr;
    logic            Halt;
    logic            Ex_PredTaken;
    logic [PC_W-1:0] Ex_PredTarget;
    logic            Mispredict;
    logic [31:0]     RedirectPC;
    logic            PcSel;
    logic [31:0]     Link;
    logic [31:0]     BrCount;
    logic [31:0]     MissCount;
    modport master (
        output F_PC, Ex_Valid, Cur_PC, Imm, AluResult, Branch, Jal, Jalr, Halt, Ex_PredTaken, Ex_PredTarget,
        input  Pred_Taken, Pred_Target, Mispredict, RedirectPC, PcSel, Link, BrCount, MissCount
    );
    modport slave (
        input  F_PC, Ex_Valid, Cur_PC, Imm, AluResult, Branch, Jal, Jalr, Halt, Ex_PredTaken, Ex_PredTarget,
        output Pred_Taken, Pred_Target, Mispredict, RedirectPC, PcSel, Link, BrCount, MissCount
    );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating history counters, branch resolution and perf counters.
// Ports: clk, rst_n (async active-low), bus (branch_predict_unit_if.slave) carrying fetch lookup,
// execute resolve/redirect and the BrCount/MissCount performance counters.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [31:0]        br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [IDX_W-1:0]   f_idx, e_idx;
    logic [TAG_W-1:0]   f_tag, e_tag;
    logic [PC_W-1:0]    target, pc4, tgt_d;
    logic [CTR_W-1:0]   ctr, ctr_d;
    logic               f_hit, e_hit, halt, resolve, taken, mis, upd;
    always_comb begin
        f_idx   = bus.F_PC[IDX_W+1:2];
        f_tag   = bus.F_PC[PC_W-1:IDX_W+2];
        f_hit   = valid_q[f_idx] && tag_q[f_idx] == f_tag && ctr_q[f_idx][CTR_W-1];
        e_idx   = bus.Cur_PC[IDX_W+1:2];
        e_tag   = bus.Cur_PC[PC_W-1:IDX_W+2];
        e_hit   = valid_q[e_idx] && tag_q[e_idx] == e_tag;
        ctr     = ctr_q[e_idx];
        // Halt overrides any control class decoded alongside it
        halt    = bus.Ex_Valid & bus.Halt;
        resolve = bus.Ex_Valid & ~bus.Halt & (bus.Branch | bus.Jal | bus.Jalr);
        taken   = bus.Jal | bus.Jalr | (bus.Branch & bus.AluResult[0]);
        target  = bus.Jalr ? {bus.AluResult[PC_W-1:1], 1'b0} : bus.Cur_PC + bus.Imm[PC_W-1:0];
        pc4     = bus.Cur_PC + PC_W'(4);
        mis     = rst_n & resolve & ((taken != bus.Ex_PredTaken) | (taken & (bus.Ex_PredTarget != target)));
        // a not-taken miss leaves the table alone; everything else writes the indexed entry
        upd     = resolve & (e_hit | taken);
        ctr_d   = !e_hit ? CTR_WT : taken ? (ctr == '1 ? ctr : ctr + 1'b1) : (ctr == '0 ? ctr : ctr - 1'b1);
        tgt_d   = taken ? target : tgt_q[e_idx];
        br_cnt_d   = br_cnt_q + 32'(resolve && br_cnt_q != '1);
        miss_cnt_d = miss_cnt_q + 32'(mis && miss_cnt_q != '1);
        bus.Pred_Taken  = rst_n & f_hit;
        bus.Pred_Target = bus.Pred_Taken ? tgt_q[f_idx] : bus.F_PC + PC_W'(4);
        bus.Mispredict  = mis;
        bus.PcSel       = rst_n & (mis | halt);
        bus.RedirectPC  = 32'(halt ? bus.Cur_PC : taken ? target : pc4);
        bus.Link        = bus.Ex_Valid ? 32'(pc4) : 32'd0;
        bus.BrCount     = br_cnt_q;
        bus.MissCount   = miss_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
            valid_q    <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= tgt_d;
                ctr_q[e_idx]   <= ctr_d;
            end
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors with hand-computed expectations for branch_predict_unit.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    branch_predict_unit_if #(.PC_W(9)) bus();
    branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CTR_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic ex(input logic [8:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                      input logic br, input logic jal, input logic jalr, input logic halt,
                      input logic pt, input logic [8:0] ptgt);
        bus.Ex_Valid = 1'b1; bus.Cur_PC = pc; bus.Imm = imm; bus.AluResult = alu;
        bus.Branch = br; bus.Jal = jal; bus.Jalr = jalr; bus.Halt = halt;
        bus.Ex_PredTaken = pt; bus.Ex_PredTarget = ptgt;
        #1;
    endtask
    task automatic idle();
        bus.Ex_Valid = 1'b0; bus.Branch = 1'b0; bus.Jal = 1'b0; bus.Jalr = 1'b0; bus.Halt = 1'b0;
        bus.Ex_PredTaken = 1'b0;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask
    task automatic look(input string tag, input logic [8:0] pc, input logic pt, input logic [8:0] tgt);
        bus.F_PC = pc;
        #1;
        chk({tag, "_taken"}, 32'(bus.Pred_Taken), 32'(pt));
        chk({tag, "_target"}, 32'(bus.Pred_Target), 32'(tgt));
    endtask
    task automatic cnt(input string tag, input int br, input int miss);
        chk({tag, "_brcount"}, bus.BrCount, 32'(br));
        chk({tag, "_misscount"}, bus.MissCount, 32'(miss));
    endtask
    task automatic res(input string tag, input logic mis, input logic sel, input logic [31:0] rpc);
        chk({tag, "_mispredict"}, 32'(bus.Mispredict), 32'(mis));
        chk({tag, "_pcsel"}, 32'(bus.PcSel), 32'(sel));
        chk({tag, "_redirect"}, bus.RedirectPC, rpc);
    endtask
    initial begin
        bus.F_PC = 9'h010; bus.Cur_PC = '0; bus.Imm = '0; bus.AluResult = '0; bus.Ex_PredTarget = '0;
        idle();
        // reset holds redirect outputs low even with a mispredicting branch presented
        ex(9'h010, 32'h20, 32'h1, 1, 0, 0, 0, 0, 9'h000);
        chk("rst_mispredict", 32'(bus.Mispredict), 32'd0);
        chk("rst_pcsel", 32'(bus.PcSel), 32'd0);
        idle();
        look("rst_lookup", 9'h010, 0, 9'h014);
        cnt("rst", 0, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // taken branch, predicted not-taken; same-cycle lookup sees pre-update contents
        ex(9'h010, 32'h20, 32'h1, 1, 0, 0, 0, 0, 9'h000);
        res("br_taken", 1, 1, 32'h030);
        chk("br_taken_link", bus.Link, 32'h014);
        look("no_bypass", 9'h010, 0, 9'h014);
        tick();
        look("after_alloc", 9'h010, 1, 9'h030);
        cnt("after_alloc", 1, 1);
        // not-taken while predicted taken: counter 10 -> 01
        ex(9'h010, 32'h20, 32'h0, 1, 0, 0, 0, 1, 9'h030);
        res("nt1", 1, 1, 32'h014);
        tick();
        look("nt1_lookup", 9'h010, 0, 9'h014);
        cnt("nt1", 2, 2);
        // correctly predicted not-taken: 01 -> 00
        ex(9'h010, 32'h20, 32'h0, 1, 0, 0, 0, 0, 9'h000);
        res("nt2", 0, 0, 32'h014);
        tick();
        // third not-taken saturates at 00
        ex(9'h010, 32'h20, 32'h0, 1, 0, 0, 0, 0, 9'h000);
        tick();
        cnt("nt3", 4, 2);
        // first taken from 00 -> 01 still predicts not-taken (a wrapped 11 would predict taken)
        ex(9'h010, 32'h20, 32'h1, 1, 0, 0, 0, 0, 9'h000);
        tick();
        look("sat_low", 9'h010, 0, 9'h014);
        ex(9'h010, 32'h20, 32'h1, 1, 0, 0, 0, 0, 9'h000);
        tick();
        look("retrain", 9'h010, 1, 9'h030);
        cnt("retrain", 6, 4);
        // JALR target has bit0 cleared and differs from the piped prediction
        ex(9'h080, 32'h0, 32'h0C5, 0, 0, 1, 0, 1, 9'h0C0);
        res("jalr", 1, 1, 32'h0C4);
        chk("jalr_link", bus.Link, 32'h084);
        tick();
        look("jalr_lookup", 9'h080, 1, 9'h0C4);
        cnt("jalr", 7, 5);
        // 0x050 aliases 0x010 and evicts it
        ex(9'h050, 32'h100, 32'h0, 0, 1, 0, 0, 0, 9'h000);
        res("jal_alias", 1, 1, 32'h150);
        tick();
        look("evicted", 9'h010, 0, 9'h014);
        look("alias_new", 9'h050, 1, 9'h150);
        // correctly predicted JAL: no redirect
        ex(9'h050, 32'h100, 32'h0, 0, 1, 0, 0, 1, 9'h150);
        res("jal_ok", 0, 0, 32'h150);
        tick();
        cnt("jal_ok", 9, 6);
        // Ex_Valid low: nothing resolves
        bus.Branch = 1'b1; bus.AluResult = 32'h1; bus.Cur_PC = 9'h010;
        #1;
        chk("exv0_mispredict", 32'(bus.Mispredict), 32'd0);
        chk("exv0_pcsel", 32'(bus.PcSel), 32'd0);
        chk("exv0_link", bus.Link, 32'd0);
        tick();
        cnt("exv0", 9, 6);
        // Halt wins over a simultaneous branch
        ex(9'h100, 32'h20, 32'h1, 1, 0, 0, 1, 0, 9'h000);
        res("halt", 0, 1, 32'h100);
        chk("halt_link", bus.Link, 32'h104);
        tick();
        cnt("halt", 9, 6);
        // target wraps modulo 2^PC_W, prediction correct
        ex(9'h1F0, 32'h20, 32'h1, 1, 0, 0, 0, 1, 9'h010);
        res("wrap", 0, 0, 32'h010);
        tick();
        look("wrap_lookup", 9'h1F0, 1, 9'h010);
        cnt("wrap", 10, 6);
        // asynchronous reset away from any clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        look("async_rst", 9'h050, 0, 9'h054);
        cnt("async_rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        look("post_rst", 9'h1F0, 0, 9'h1F4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
